inst_mem_loader: RTL

- Writer-side counterpart to the instruction fetch stage.
- Holds the 16 x 8-bit instruction memory that fetch reads.
- Fills that memory from a byte-stream load port with a valid/ready handshake.
- Keeps the core held until a complete, checksum-verified program has been written.

---
 rtl/inst_mem_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: 16 x 8-bit memory filled from a header/data(/checksum) byte stream.
// Optional checksum phase is enabled by defining INST_MEM_LOADER_CSUM_EN.
module inst_mem_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CSUM,
    S_RESP_OK,
    S_RESP_ERR
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_remaining;  // data bytes still to come, minus one
  logic                  r_in_ready;
  logic                  r_core_hold;
  logic                  r_load_done;

  logic                  w_xfer;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_hdr_start;
  logic [ADDR_WIDTH-1:0] w_hdr_cnt_m1;

  assign w_xfer       = in_valid & r_in_ready;
  assign w_wr_en      = w_xfer & (r_state == S_DATA);
  // Header carries the start address in the upper field and count-1 in the lower one.
  assign w_hdr_start  = in_data[DATA_WIDTH-1 -: ADDR_WIDTH];
  assign w_hdr_cnt_m1 = in_data[ADDR_WIDTH-1:0];

  assign in_ready  = r_in_ready;
  assign rd_data   = r_rd_data;
  assign core_hold = r_core_hold;
  assign load_done = r_load_done;

  // NOTE: the memory is reset word by word because a reset must leave no stale program
  // behind; that makes it a register file rather than an inferable RAM macro.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_data <= '0;
    end else begin
      // NOTE: non-blocking assignments make a same-address write and read return the old word.
      r_rd_data <= r_mem[rd_addr];
      if (w_wr_en) r_mem[r_wr_ptr] <= in_data;
    end
  end

`ifdef INST_MEM_LOADER_CSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;
  logic [DATA_WIDTH-1:0] w_csum_total;
  logic                  r_load_err;

  assign w_csum_total = r_sum + in_data;
  assign load_err     = r_load_err;
`else
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_in_ready  <= 1'b1;
      r_core_hold <= 1'b1;
      r_load_done <= 1'b0;
`ifdef INST_MEM_LOADER_CSUM_EN
      r_sum       <= '0;
      r_load_err  <= 1'b0;
`endif
    end else begin
      r_load_done <= 1'b0;
`ifdef INST_MEM_LOADER_CSUM_EN
      r_load_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_wr_ptr    <= w_hdr_start;
            r_remaining <= w_hdr_cnt_m1;
            r_core_hold <= 1'b1;
            r_state     <= S_DATA;
`ifdef INST_MEM_LOADER_CSUM_EN
            r_sum       <= '0;
`endif
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
`ifdef INST_MEM_LOADER_CSUM_EN
            r_sum       <= r_sum + in_data;
            if (r_remaining == '0) r_state <= S_CSUM;
`else
            if (r_remaining == '0) begin
              r_state     <= S_RESP_OK;
              r_in_ready  <= 1'b0;
              r_load_done <= 1'b1;
            end
`endif
          end
        end
`ifdef INST_MEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (w_csum_total == '0) begin
              r_state     <= S_RESP_OK;
              r_load_done <= 1'b1;
            end else begin
              r_state    <= S_RESP_ERR;
              r_load_err <= 1'b1;
            end
          end
        end
        S_RESP_ERR: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
`endif
        S_RESP_OK: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_core_hold <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
